hd44780_ctrl: RTL and testbench

Write controller for an HD44780 character LCD in 8-bit, write-only mode. It sits directly downstream of the clock divider, which supplies a one-cycle `tick` enable that paces every LCD bus phase. It runs the power-on initialisation sequence on its own, then accepts command and data bytes over a valid/ready handshake and drives the RS, RW, E and DB[7:0] pins.

---
 rtl/hd44780_pkg.sv | 28 ++
 rtl/hd44780_byte_wr.sv | 96 +++++++++
 rtl/hd44780_ctrl.sv | 132 +++++++++++++
 tb/tb_hd44780_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hd44780_pkg.sv
// Shared types and constants for the HD44780 write-only controller:
// FSM state encoding, the power-on init ROM and the long-wait command decode.
package hd44780_pkg;

  typedef enum logic [2:0] {
    PWRUP,
    INIT,
    SETUP,
    EHIGH,
    WAIT,
    IDLE
  } state_e;

  localparam int INIT_LEN = 6;
  localparam int IDX_W    = $clog2(INIT_LEN);

  // function set 8-bit/2-line (x3), display on, clear, entry mode increment
  localparam logic [7:0] INIT_ROM [INIT_LEN] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;

  // Clear (0x01) and return-home (0x02/0x03) need the long execution delay.
  function automatic logic is_long_wait(input logic rs, input logic [7:0] data);
    return !rs && ((data == CMD_CLEAR) || (data[7:1] == CMD_HOME[7:1]));
  endfunction

endpackage

// File: rtl/hd44780_byte_wr.sv
// One LCD bus write: SETUP -> EHIGH -> WAIT, each phase paced by tick.
// RS/DATA are latched on start and held until the next start.
module hd44780_byte_wr #(
  parameter int CMD_WAIT_TICKS  = 1,
  parameter int LONG_WAIT_TICKS = 4,
  parameter int CNT_W           = 4
) (
  input  logic       clkIn,
  input  logic       rst,
  input  logic       tick,
  input  logic       start,
  input  logic       rs,
  input  logic [7:0] data,
  output logic       busy,
  output logic       done,
  output logic       lcd_rs,
  output logic       lcd_e,
  output logic [7:0] lcd_data
);
  import hd44780_pkg::*;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rs_q, rs_d;
  logic [7:0]       data_q, data_d;
  logic             e_q, e_d;

  always_ff @(posedge clkIn or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      e_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      e_q     <= e_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rs_d    = rs_q;
    data_d  = data_q;
    e_d     = e_q;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SETUP;
          rs_d    = rs;
          data_d  = data;
        end
      end
      SETUP: begin
        if (tick) begin
          state_d = EHIGH;
          e_d     = 1'b1;
        end
      end
      EHIGH: begin
        if (tick) begin
          state_d = WAIT;
          e_d     = 1'b0;
          cnt_d   = is_long_wait(rs_q, data_q) ? CNT_W'(LONG_WAIT_TICKS) : CNT_W'(CMD_WAIT_TICKS);
        end
      end
      WAIT: begin
        // The tick that would take the count to zero also ends the byte.
        if (tick) begin
          if (cnt_q <= CNT_W'(1)) begin
            cnt_d   = '0;
            state_d = IDLE;
            done    = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        e_d     = 1'b0;
      end
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign lcd_rs   = rs_q;
  assign lcd_e    = e_q;
  assign lcd_data = data_q;

endmodule

// File: rtl/hd44780_ctrl.sv
// HD44780 8-bit write-only controller: power-up delay, init ROM playback,
// then host bytes over a valid/ready handshake.
module hd44780_ctrl #(
  parameter int PWRUP_TICKS     = 100,
  parameter int CMD_WAIT_TICKS  = 1,
  parameter int LONG_WAIT_TICKS = 4
) (
  input  logic       clkIn,
  input  logic       rst,
  input  logic       tick,
  input  logic       wr_valid,
  input  logic       wr_rs,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  output logic       init_done,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_data
);
  import hd44780_pkg::*;

  localparam int MAX_TICKS = (PWRUP_TICKS > LONG_WAIT_TICKS) ? PWRUP_TICKS : LONG_WAIT_TICKS;
  localparam int CNT_W     = $clog2(MAX_TICKS) + 1;

  // Top-level states used: PWRUP, INIT, IDLE, and WAIT while a host byte is in flight.
  state_e           state_q, state_d;
  logic [CNT_W-1:0] pwr_cnt_q, pwr_cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             wr_ready_q, wr_ready_d;
  logic             init_done_q, init_done_d;

  logic             byte_start;
  logic             byte_rs;
  logic [7:0]       byte_data;
  logic             byte_busy;
  logic             byte_done;

  always_ff @(posedge clkIn or posedge rst) begin
    if (rst) begin
      state_q     <= PWRUP;
      pwr_cnt_q   <= '0;
      idx_q       <= '0;
      wr_ready_q  <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pwr_cnt_q   <= pwr_cnt_d;
      idx_q       <= idx_d;
      wr_ready_q  <= wr_ready_d;
      init_done_q <= init_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pwr_cnt_d   = pwr_cnt_q;
    idx_d       = idx_q;
    wr_ready_d  = wr_ready_q;
    init_done_d = init_done_q;
    byte_start  = 1'b0;
    byte_rs     = 1'b0;
    byte_data   = INIT_ROM[idx_q];
    case (state_q)
      PWRUP: begin
        if (tick) begin
          if (pwr_cnt_q >= CNT_W'(PWRUP_TICKS - 1)) begin
            pwr_cnt_d = '0;
            state_d   = INIT;
          end else begin
            pwr_cnt_d = pwr_cnt_q + CNT_W'(1);
          end
        end
      end
      INIT: begin
        // Launch init bytes on a tick so the bus only moves on tick edges.
        byte_start = tick && !byte_busy;
        if (byte_done) begin
          if (idx_q == IDX_W'(INIT_LEN - 1)) begin
            idx_d       = '0;
            state_d     = IDLE;
            wr_ready_d  = 1'b1;
            init_done_d = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      IDLE: begin
        byte_rs   = wr_rs;
        byte_data = wr_data;
        if (wr_valid && wr_ready_q) begin
          byte_start = 1'b1;
          wr_ready_d = 1'b0;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (byte_done) begin
          wr_ready_d = 1'b1;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d = PWRUP;
      end
    endcase
  end

  hd44780_byte_wr #(
    .CMD_WAIT_TICKS (CMD_WAIT_TICKS),
    .LONG_WAIT_TICKS(LONG_WAIT_TICKS),
    .CNT_W          (CNT_W)
  ) u_byte_wr (
    .clkIn   (clkIn),
    .rst     (rst),
    .tick    (tick),
    .start   (byte_start),
    .rs      (byte_rs),
    .data    (byte_data),
    .busy    (byte_busy),
    .done    (byte_done),
    .lcd_rs  (lcd_rs),
    .lcd_e   (lcd_e),
    .lcd_data(lcd_data)
  );

  assign wr_ready  = wr_ready_q;
  assign init_done = init_done_q;
  assign lcd_rw    = 1'b0;

endmodule

// File: tb/tb_hd44780_ctrl.sv
// Directed bench for hd44780_ctrl: tick every 4 clocks, PWRUP_TICKS=3,
// a negedge monitor timestamps E pulses, waits and handshakes.
module tb_hd44780_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       wr_valid;
  logic       wr_rs;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       init_done;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;
  logic [7:0] lcd_data;

  hd44780_ctrl #(
    .PWRUP_TICKS    (3),
    .CMD_WAIT_TICKS (1),
    .LONG_WAIT_TICKS(4)
  ) dut (
    .clkIn    (clk),
    .rst      (rst),
    .tick     (tick),
    .wr_valid (wr_valid),
    .wr_rs    (wr_rs),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .init_done(init_done),
    .lcd_rs   (lcd_rs),
    .lcd_rw   (lcd_rw),
    .lcd_e    (lcd_e),
    .lcd_data (lcd_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Monitor records
  int q_data [$];   // {rs,data} at each E rise
  int q_ehigh [$];  // E high width in clocks
  int q_wait [$];   // clocks from E fall to wr_ready rise
  int q_setup [$];  // clocks from accept edge to E rise
  int e_rise_cyc, e_fall_cyc, acc_cyc, idone_cyc, ready_rise_cyc;
  int rise_word;
  bit acc_pending;
  bit e_prev, ready_prev, idone_prev;

  logic [7:0] rom [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial forever @(posedge clk) cyc++;

  initial begin
    int ph;
    ph   = 0;
    tick = 1'b0;
    forever @(negedge clk) begin
      tick = (ph == 3);
      ph   = (ph + 1) % 4;
    end
  end

  initial begin
    e_prev = 0; ready_prev = 0; idone_prev = 0; acc_pending = 0;
    forever @(negedge clk) begin
      if (rst) begin
        e_prev = 0; ready_prev = 0; idone_prev = 0; acc_pending = 0;
      end else begin
        if (lcd_e && !e_prev) begin
          e_rise_cyc = cyc;
          rise_word  = int'({lcd_rs, lcd_data});
          q_data.push_back(rise_word);
          if (acc_pending) begin
            q_setup.push_back(cyc - acc_cyc);
            acc_pending = 0;
          end
        end
        if (!lcd_e && e_prev) begin
          q_ehigh.push_back(cyc - e_rise_cyc);
          e_fall_cyc = cyc;
          check("bus_hold_through_e", int'({lcd_rs, lcd_data}), rise_word);
        end
        if (wr_ready && !ready_prev) begin
          q_wait.push_back(cyc - e_fall_cyc);
          ready_rise_cyc = cyc;
        end
        if (!wr_ready && ready_prev) begin
          acc_cyc     = cyc;
          acc_pending = 1;
        end
        if (init_done && !idone_prev) idone_cyc = cyc;
        e_prev     = lcd_e;
        ready_prev = wr_ready;
        idone_prev = init_done;
      end
    end
  end

  task automatic wait_ready();
    for (int i = 0; i < 300 && !wr_ready; i++) step();
    check("ready_timeout", int'(wr_ready), 1);
  endtask

  task automatic check_init();
    for (int i = 0; i < 2000 && !init_done; i++) step();
    wr_valid = 1'b0;
    check("init_done_up", int'(init_done), 1);
    check("ready_with_init_done", ready_rise_cyc, idone_cyc);
    check("init_done_after_last_wait", idone_cyc - e_fall_cyc, 4);
    repeat (40) step();
    check("init_pulse_count", q_data.size(), 6);
    for (int i = 0; i < 6; i++) begin
      check("init_byte", (i < q_data.size()) ? q_data[i] : -1, int'({1'b0, rom[i]}));
      check("init_e_width", (i < q_ehigh.size()) ? q_ehigh[i] : -1, 4);
    end
    $display("init sequence: %0d E pulses, init_done at cycle %0d", q_data.size(), idone_cyc);
  endtask

  task automatic host_write(input logic rs, input logic [7:0] data, input int exp_wait);
    int n0;
    wait_ready();
    n0       = q_data.size();
    wr_rs    = rs;
    wr_data  = data;
    wr_valid = 1'b1;
    step();
    wr_valid = 1'b0;
    check("accept_ready_low", int'(wr_ready), 0);
    check("accept_bus", int'({lcd_rs, lcd_data}), int'({rs, data}));
    wait_ready();
    check("pulse_count", q_data.size(), n0 + 1);
    check("pulse_word", (q_data.size() > 0) ? q_data[$] : -1, int'({rs, data}));
    check("e_width", (q_ehigh.size() > 0) ? q_ehigh[$] : -1, 4);
    check("wait_width", (q_wait.size() > 0) ? q_wait[$] : -1, exp_wait);
    check("setup_range", int'(q_setup.size() > 0 && q_setup[$] >= 1 && q_setup[$] <= 4), 1);
    $display("write rs=%0d data=0x%02h wait_clks=%0d", rs, data, (q_wait.size() > 0) ? q_wait[$] : -1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    rst = 1'b1; wr_valid = 1'b0; wr_rs = 1'b0; wr_data = 8'h00;
    repeat (3) step();
    check("rst_lcd_e", int'(lcd_e), 0);
    check("rst_lcd_data", int'(lcd_data), 0);
    check("rst_lcd_rs", int'(lcd_rs), 0);
    check("rst_lcd_rw", int'(lcd_rw), 0);
    check("rst_wr_ready", int'(wr_ready), 0);
    check("rst_init_done", int'(init_done), 0);
    rst = 1'b0;
    repeat (2) step();
    check("pwrup_ready_low", int'(wr_ready), 0);
    check("pwrup_e_low", int'(lcd_e), 0);
    check_init();

    host_write(1'b1, 8'h41, 4);
    host_write(1'b0, 8'h01, 16);
    host_write(1'b1, 8'h01, 4);
    host_write(1'b0, 8'h80, 4);
    host_write(1'b0, 8'h04, 4);

    // back-to-back with wr_valid held and wr_data changing while busy
    wait_ready();
    n0 = q_data.size();
    wr_rs = 1'b1; wr_data = 8'h48; wr_valid = 1'b1;
    step();
    check("b2b_first_accept", int'(wr_ready), 0);
    check("b2b_first_bus", int'(lcd_data), 8'h48);
    wr_data = 8'h49;
    for (int i = 0; i < 300 && !wr_ready; i++) begin
      step();
      if (!wr_ready) check("b2b_busy_data", int'(lcd_data), 8'h48);
    end
    check("b2b_hold_between", int'(lcd_data), 8'h48);
    step();
    wr_valid = 1'b0;
    check("b2b_second_accept", int'(wr_ready), 0);
    check("b2b_second_bus", int'(lcd_data), 8'h49);
    wait_ready();
    check("b2b_pulse_count", q_data.size(), n0 + 2);
    check("b2b_word0", (q_data.size() >= 2) ? q_data[q_data.size()-2] : -1, 9'h148);
    check("b2b_word1", (q_data.size() >= 1) ? q_data[$] : -1, 9'h149);
    $display("write back-to-back 0x48,0x49 pulses=%0d", q_data.size() - n0);

    // accept on the same edge as a tick
    wait_ready();
    for (int i = 0; i < 8 && !tick; i++) step();
    wr_rs = 1'b1; wr_data = 8'h5A; wr_valid = 1'b1;
    step();
    wr_valid = 1'b0;
    check("tick_accept_ready_low", int'(wr_ready), 0);
    wait_ready();
    check("tick_accept_setup", (q_setup.size() > 0) ? q_setup[$] : -1, 4);
    check("tick_accept_word", (q_data.size() > 0) ? q_data[$] : -1, 9'h15A);
    $display("write tick-coincident data=0x5A setup_clks=%0d", (q_setup.size() > 0) ? q_setup[$] : -1);

    // reset mid-init while E is high
    rst = 1'b1;
    step();
    q_data.delete(); q_ehigh.delete(); q_wait.delete(); q_setup.delete();
    rst = 1'b0;
    for (int i = 0; i < 2000 && !(lcd_e && q_data.size() == 3); i++) step();
    check("midinit_e_seen", int'(lcd_e), 1);
    rst = 1'b1;
    #1;
    check("async_rst_e", int'(lcd_e), 0);
    check("async_rst_data", int'(lcd_data), 0);
    check("async_rst_init_done", int'(init_done), 0);
    check("async_rst_ready", int'(wr_ready), 0);
    repeat (2) step();
    q_data.delete(); q_ehigh.delete(); q_wait.delete(); q_setup.delete();
    rst = 1'b0;
    // a host request during init must be ignored
    wr_rs = 1'b1; wr_data = 8'hFF; wr_valid = 1'b1;
    check_init();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
